// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state, owner and bus-direction definitions for the memory bus arbiter
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } arb_owner_e;

  localparam logic BUS_WRITE = 1'b1;
  localparam logic BUS_READ  = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_wait_cnt.sv
// rtl/arb_wait_cnt.sv - saturating counter with clear, increment and terminal-count flag
module arb_wait_cnt #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_CNT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_CNT);

  logic [WIDTH-1:0] cnt;

  // Clear wins over increment; the count holds once it reaches MAX_CNT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == MAX_V);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data memory bus arbiter with data priority, fetch anti-starvation and bus watchdog
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned TIMEOUT_CYC  = 16,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic              grant_d
);

  localparam int unsigned TO_W     = cnt_width(TIMEOUT_CYC - 1);
  localparam int unsigned STREAK_W = cnt_width(MAX_D_STREAK);

  arb_state_e        state, state_nxt;
  logic              bus_valid_nxt, bus_we_nxt, grant_d_nxt, busy_nxt;
  logic [ADDR_W-1:0] bus_addr_nxt;
  logic [DATA_W-1:0] bus_wdata_nxt, if_rdata_nxt, d_rdata_nxt;
  logic              if_ack_nxt, if_err_nxt, d_ack_nxt, d_err_nxt;
  logic              streak_clr, streak_inc, streak_tc;
  logic              to_clr, to_inc, to_tc;
  logic              done, timed_out;
  logic [DATA_W-1:0] resp_data;

  arb_wait_cnt #(.WIDTH(TO_W), .MAX_CNT(TIMEOUT_CYC - 1)) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (to_clr),
    .inc   (to_inc),
    .tc    (to_tc)
  );

  arb_wait_cnt #(.WIDTH(STREAK_W), .MAX_CNT(MAX_D_STREAK)) u_streak_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (streak_clr),
    .inc   (streak_inc),
    .tc    (streak_tc)
  );

  assign to_clr = (state != ARB_BUSY);
  assign to_inc = (state == ARB_BUSY) && !bus_ready;

  always_comb begin
    state_nxt     = state;
    bus_we_nxt    = bus_we;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
    grant_d_nxt   = grant_d;
    if_ack_nxt    = 1'b0;
    d_ack_nxt     = 1'b0;
    if_err_nxt    = 1'b0;
    d_err_nxt     = 1'b0;
    if_rdata_nxt  = '0;
    d_rdata_nxt   = '0;
    streak_clr    = 1'b0;
    streak_inc    = 1'b0;
    done          = 1'b0;
    timed_out     = 1'b0;
    resp_data     = '0;

    case (state)
      ARB_IDLE: begin
        // Data wins unless fetch has already waited through a full data streak.
        if (d_req && !(if_req && streak_tc)) begin
          state_nxt     = ARB_BUSY;
          grant_d_nxt   = GRANT_D;
          bus_we_nxt    = d_we;
          bus_addr_nxt  = d_addr;
          bus_wdata_nxt = d_wdata;
          streak_inc    = if_req;
          streak_clr    = !if_req;
        end else if (if_req) begin
          state_nxt     = ARB_BUSY;
          grant_d_nxt   = GRANT_IF;
          bus_we_nxt    = BUS_READ;
          bus_addr_nxt  = if_addr;
          bus_wdata_nxt = '0;
          streak_clr    = 1'b1;
        end
      end
      ARB_BUSY: begin
        // A ready on the limit cycle is still a success.
        if (bus_ready) begin
          done      = 1'b1;
          resp_data = (bus_we == BUS_WRITE) ? '0 : bus_rdata;
        end else if (to_tc) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end
        if (done) begin
          state_nxt = ARB_RESP;
          if (grant_d == GRANT_D) begin
            d_ack_nxt   = 1'b1;
            d_err_nxt   = timed_out;
            d_rdata_nxt = resp_data;
          end else begin
            if_ack_nxt   = 1'b1;
            if_err_nxt   = timed_out;
            if_rdata_nxt = resp_data;
          end
        end
      end
      ARB_RESP: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase

    bus_valid_nxt = (state_nxt == ARB_BUSY);
    busy_nxt      = (state_nxt != ARB_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      grant_d   <= 1'b0;
      busy      <= 1'b0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      bus_valid <= bus_valid_nxt;
      bus_we    <= bus_we_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_wdata <= bus_wdata_nxt;
      grant_d   <= grant_d_nxt;
      busy      <= busy_nxt;
      if_ack    <= if_ack_nxt;
      if_err    <= if_err_nxt;
      if_rdata  <= if_rdata_nxt;
      d_ack     <= d_ack_nxt;
      d_err     <= d_err_nxt;
      d_rdata   <= d_rdata_nxt;
    end
  end

endmodule
